// File: rtl/mem_ctrl.sv
// Cache-pair memory responder: arbitrates icache/dcache word requests and serialises them into
// byte accesses on a synchronous 8-bit RAM. Define MEM_CTRL_RR_ARB_EN for round-robin arbitration.
module mem_ctrl #(
   parameter int ADDR_WIDTH  = 17,
   parameter int RAM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            ic_rw_flag,
   input  logic [31:0]           ic_addr,
   output logic [31:0]           ic_read_data,
   output logic                  ic_busy,
   output logic                  ic_done,
   input  logic [1:0]            dc_rw_flag,
   input  logic [31:0]           dc_addr,
   output logic [31:0]           dc_read_data,
   input  logic [31:0]           dc_write_data,
   input  logic [3:0]            dc_write_mask,
   output logic                  dc_busy,
   output logic                  dc_done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]            ram_din,
   output logic                  ram_we,
   input  logic [7:0]            ram_dout
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   // Last read cycle: byte 3 issued at count 3, captured RAM_LATENCY counts later.
   localparam logic [2:0] ReadLast = 3'(3 + RAM_LATENCY);

   state_e                r_state, w_state_next;
   logic                  r_sel_dc;
   logic [2:0]            r_cyc;
   logic [ADDR_WIDTH-3:0] r_word;
   logic [31:0]           r_wdata;
   logic [3:0]            r_mask;
   logic [ADDR_WIDTH-1:0] r_ram_addr;
   logic [7:0]            r_ram_din;
   logic                  r_ram_we;
   logic [31:0]           r_ic_rdata, r_dc_rdata;

   logic w_ic_req, w_dc_req, w_grant_dc, w_accept, w_is_wr;
   logic w_unused_bits;

   function automatic logic [1:0] first_bit(input logic [3:0] m);
      if (m[0]) return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else return 2'd3;
   endfunction

   assign w_ic_req      = ic_rw_flag[0];
   assign w_dc_req      = dc_rw_flag[0] | dc_rw_flag[1];
   assign w_accept      = (r_state == StIdle) & (w_ic_req | w_dc_req);
   assign w_is_wr       = w_grant_dc & dc_rw_flag[1];
   assign w_unused_bits = ^{ic_rw_flag[1], ic_addr, dc_addr};

`ifdef MEM_CTRL_RR_ARB_EN
   logic r_last_dc;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_last_dc <= 1'b0;
      else if (w_accept) r_last_dc <= w_grant_dc;
   end
   // On contention the port not served last time wins; reset state favours dcache.
   assign w_grant_dc = w_dc_req & (~w_ic_req | ~r_last_dc);
`else
   assign w_grant_dc = w_dc_req;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= StIdle;
      else r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               if (!w_is_wr) w_state_next = StRead;
               else if (dc_write_mask == 4'b0000) w_state_next = StDone;
               else w_state_next = StWrite;
            end
         end
         StRead:  if (r_cyc == ReadLast) w_state_next = StDone;
         StWrite: if (r_mask == 4'b0000) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel_dc   <= 1'b0;
         r_cyc      <= '0;
         r_word     <= '0;
         r_wdata    <= '0;
         r_mask     <= '0;
         r_ram_addr <= '0;
         r_ram_din  <= '0;
         r_ram_we   <= 1'b0;
         r_ic_rdata <= '0;
         r_dc_rdata <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_sel_dc <= w_grant_dc;
                  r_cyc    <= '0;
                  r_wdata  <= dc_write_data;
                  r_word   <= w_grant_dc ? dc_addr[ADDR_WIDTH-1:2] : ic_addr[ADDR_WIDTH-1:2];
                  if (w_is_wr) begin
                     r_mask <= dc_write_mask & ~(4'b0001 << first_bit(dc_write_mask));
                     if (dc_write_mask != 4'b0000) begin
                        r_ram_addr <= {dc_addr[ADDR_WIDTH-1:2], first_bit(dc_write_mask)};
                        r_ram_din  <= dc_write_data[8*first_bit(dc_write_mask) +: 8];
                        r_ram_we   <= 1'b1;
                     end
                  end else begin
                     r_ram_addr <= {(w_grant_dc ? dc_addr[ADDR_WIDTH-1:2]
                                                : ic_addr[ADDR_WIDTH-1:2]), 2'b00};
                  end
               end
            end
            StRead: begin
               r_cyc <= r_cyc + 3'd1;
               if (r_cyc < 3'd3) r_ram_addr <= {r_word, r_cyc[1:0] + 2'd1};
               for (int k = 0; k < 4; k++) begin
                  if (r_cyc == 3'(RAM_LATENCY + k)) begin
                     if (r_sel_dc) r_dc_rdata[8*k +: 8] <= ram_dout;
                     else r_ic_rdata[8*k +: 8] <= ram_dout;
                  end
               end
            end
            StWrite: begin
               if (r_mask != 4'b0000) begin
                  r_ram_addr <= {r_word, first_bit(r_mask)};
                  r_ram_din  <= r_wdata[8*first_bit(r_mask) +: 8];
                  r_mask     <= r_mask & ~(4'b0001 << first_bit(r_mask));
               end else begin
                  r_ram_we <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ic_busy      = 1'b0;
      dc_busy      = 1'b0;
      ic_done      = 1'b0;
      dc_done      = 1'b0;
      if (r_state == StRead || r_state == StWrite) begin
         ic_busy = ~r_sel_dc;
         dc_busy = r_sel_dc;
      end
      if (r_state == StDone) begin
         ic_done = ~r_sel_dc;
         dc_done = r_sel_dc;
      end
      ic_read_data = r_ic_rdata;
      dc_read_data = r_dc_rdata;
      ram_addr     = r_ram_addr;
      ram_din      = r_ram_din;
      ram_we       = r_ram_we;
   end

endmodule
